// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Frame-rate game sequencer. Owns the IDLE/COUNTDOWN/PLAY/DEAD
//               sequence, gates obstacle motion through rdy, and keeps a
//               3-digit BCD score and high score for the HUD.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl #(
  parameter logic [7:0] START_KEY    = 8'h2C,
  parameter logic [9:0] COUNT_FRAMES = 10'd180,
  parameter logic [9:0] DEAD_HOLD    = 10'd90
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  key,
  input  logic        score,
  input  logic        gameover,
  output logic        rdy,
  output logic [1:0]  state,
  output logic [11:0] score_bcd,
  output logic [11:0] hiscore_bcd,
  output logic        new_best,
  output logic [1:0]  count_digit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DEAD  = 2'b11
  } state_t;

  state_t      r_state;
  logic [9:0]  r_timer;
  logic [7:0]  r_key_prev;
  logic        r_rdy;
  logic [11:0] r_score;
  logic [11:0] r_hiscore;
  logic        r_new_best;
  logic [1:0]  r_count_digit;

  logic        w_start_evt;
  logic [11:0] w_score_inc;
  logic [1:0]  w_cd_start;
  logic [1:0]  w_cd_next;

  // Seconds left shown during countdown: timer/60+1, clamped to 3.
  function automatic logic [1:0] f_seconds(input logic [9:0] t);
    if (t >= 10'd120)     f_seconds = 2'd3;
    else if (t >= 10'd60) f_seconds = 2'd2;
    else                  f_seconds = 2'd1;
  endfunction

  // Only the press edge of the start key counts; a held key never retriggers.
  assign w_start_evt = (key == START_KEY) && (r_key_prev != START_KEY);

  // Digit to display for the timer value being loaded this frame.
  assign w_cd_start = f_seconds(COUNT_FRAMES - 10'd1);
  assign w_cd_next  = f_seconds(r_timer - 10'd1);

  // Score + 1 in BCD with decimal carry, saturating at 999.
  always_comb begin
    w_score_inc = r_score;
    if (r_score != 12'h999) begin
      if (r_score[3:0] != 4'd9) begin
        w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end else begin
        w_score_inc[3:0] = 4'd0;
        if (r_score[7:4] != 4'd9) begin
          w_score_inc[7:4] = r_score[7:4] + 4'd1;
        end else begin
          w_score_inc[7:4]  = 4'd0;
          w_score_inc[11:8] = r_score[11:8] + 4'd1;
        end
      end
    end
  end

  // Previous keycode for edge detection.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) r_key_prev <= 8'h00;
    else        r_key_prev <= key;
  end

  // Game sequencer with registered outputs.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= 10'd0;
      r_rdy         <= 1'b0;
      r_score       <= 12'h000;
      r_hiscore     <= 12'h000;
      r_new_best    <= 1'b0;
      r_count_digit <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rdy         <= 1'b0;
          r_count_digit <= 2'd0;
          if (w_start_evt) begin
            r_state       <= ST_COUNT;
            r_timer       <= COUNT_FRAMES - 10'd1;
            r_score       <= 12'h000;
            r_new_best    <= 1'b0;
            r_count_digit <= w_cd_start;
          end
        end
        ST_COUNT: begin
          // Keys, score and gameover are all ignored while counting down.
          if (r_timer == 10'd0) begin
            r_state       <= ST_PLAY;
            r_rdy         <= 1'b1;
            r_count_digit <= 2'd0;
          end else begin
            r_rdy         <= 1'b0;
            r_timer       <= r_timer - 10'd1;
            r_count_digit <= w_cd_next;
          end
        end
        ST_PLAY: begin
          r_count_digit <= 2'd0;
          if (gameover) begin
            // Collision wins over a simultaneous score pulse.
            r_state <= ST_DEAD;
            r_rdy   <= 1'b0;
            r_timer <= DEAD_HOLD - 10'd1;
            // Digits are always 0-9, so a plain unsigned compare of the
            // packed BCD value orders the same as a digit-wise compare.
            if (r_score > r_hiscore) begin
              r_hiscore  <= r_score;
              r_new_best <= 1'b1;
            end
          end else begin
            r_rdy <= 1'b1;
            if (score) r_score <= w_score_inc;
          end
        end
        ST_DEAD: begin
          r_rdy         <= 1'b0;
          r_count_digit <= 2'd0;
          if (w_start_evt && (r_timer == 10'd0)) begin
            r_state       <= ST_COUNT;
            r_timer       <= COUNT_FRAMES - 10'd1;
            r_score       <= 12'h000;
            r_new_best    <= 1'b0;
            r_count_digit <= w_cd_start;
          end else if (r_timer != 10'd0) begin
            r_timer <= r_timer - 10'd1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_rdy         <= 1'b0;
          r_count_digit <= 2'd0;
        end
      endcase
    end
  end

  assign rdy         = r_rdy;
  assign state       = r_state;
  assign score_bcd   = r_score;
  assign hiscore_bcd = r_hiscore;
  assign new_best    = r_new_best;
  assign count_digit = r_count_digit;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_ctrl
// Description : Self-checking bench for game_ctrl. Directed game scenarios
//               followed by random frames, all compared every frame against
//               a behavioural model built on integer scores and frame counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  key;
  logic        score;
  logic        gameover;
  logic        rdy;
  logic [1:0]  state;
  logic [11:0] score_bcd;
  logic [11:0] hiscore_bcd;
  logic        new_best;
  logic [1:0]  count_digit;

  game_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .key         (key),
    .score       (score),
    .gameover    (gameover),
    .rdy         (rdy),
    .state       (state),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .new_best    (new_best),
    .count_digit (count_digit)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase codes follow the externally visible state encoding.
  localparam int P_IDLE = 0, P_COUNT = 1, P_PLAY = 2, P_DEAD = 3;
  int         m_phase;
  int         m_cnt;      // countdown frame number, 1..180
  int         m_dead;     // frames spent in DEAD so far, from 1
  int         m_score;    // plain integer score
  int         m_hi;
  bit         m_best;
  logic [7:0] m_prev_key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_dead = 0;
    m_score = 0; m_hi = 0; m_best = 0; m_prev_key = 8'h00;
  endtask

  task automatic model_begin_run();
    m_phase = P_COUNT; m_cnt = 1; m_score = 0; m_best = 0;
  endtask

  task automatic model_step(input logic [7:0] k, input logic s, input logic g);
    bit start;
    start = (k == 8'h2C) && (m_prev_key != 8'h2C);
    m_prev_key = k;
    case (m_phase)
      P_IDLE:  if (start) model_begin_run();
      P_COUNT: if (m_cnt == 180) m_phase = P_PLAY; else m_cnt++;
      P_PLAY: begin
        if (g) begin
          m_phase = P_DEAD; m_dead = 1;
          if (m_score > m_hi) begin m_hi = m_score; m_best = 1; end
        end else if (s) begin
          m_score = (m_score < 999) ? m_score + 1 : 999;
        end
      end
      default: begin
        if (start && m_dead >= 90) model_begin_run();
        else m_dead++;
      end
    endcase
  endtask

  task automatic compare_all();
    int secs;
    // Seconds remaining = ceil(frames remaining / 60).
    secs = (m_phase == P_COUNT) ? ((181 - m_cnt) + 59) / 60 : 0;
    check("state",       32'(state),       32'(m_phase));
    check("rdy",         32'(rdy),         32'(m_phase == P_PLAY));
    check("score_bcd",   32'(score_bcd),   32'(to_bcd(m_score)));
    check("hiscore_bcd", 32'(hiscore_bcd), 32'(to_bcd(m_hi)));
    check("new_best",    32'(new_best),    32'(m_best));
    check("count_digit", 32'(count_digit), 32'(secs));
  endtask

  // One frame: inputs already away from the edge, model steps with the DUT.
  task automatic frame(input logic [7:0] k, input logic s, input logic g);
    key = k; score = s; gameover = g;
    @(posedge frame_clk);
    model_step(k, s, g);
    @(negedge frame_clk);
    compare_all();
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) frame(8'h00, 1'b0, 1'b0);
  endtask

  // Press start for one frame from a released key, then run out the countdown.
  task automatic start_and_countdown();
    frame(8'h2C, 1'b0, 1'b0);
    idle_frames(180);
  endtask

  initial begin
    Reset = 1'b0; key = 8'h00; score = 1'b0; gameover = 1'b0;
    model_reset();
    @(negedge frame_clk);
    @(negedge frame_clk);
    compare_all();
    Reset = 1'b1;

    // Idle after reset.
    idle_frames(10);
    check("idle_state", 32'(state), 32'h0);

    // Held start key: one countdown of 180 frames, then play, no retrigger.
    for (int i = 0; i < 200; i++) frame(8'h2C, 1'b0, 1'b0);
    check("play_after_hold", 32'(state), 32'h2);

    // 105 separate score pulses then a collision.
    for (int i = 0; i < 105; i++) begin
      frame(8'h00, 1'b1, 1'b0);
      frame(8'h00, 1'b0, 1'b0);
    end
    check("score_105", 32'(score_bcd), 32'h105);
    frame(8'h00, 1'b0, 1'b1);
    check("hi_105", 32'(hiscore_bcd), 32'h105);
    check("best_first", 32'(new_best), 32'h1);

    // Early restart during the dead hold is ignored.
    idle_frames(29);
    for (int i = 0; i < 3; i++) frame(8'h2C, 1'b0, 1'b0);
    check("early_restart", 32'(state), 32'h3);
    idle_frames(60);
    frame(8'h2C, 1'b0, 1'b0);
    check("restart_state", 32'(state), 32'h1);
    check("restart_score", 32'(score_bcd), 32'h000);
    idle_frames(180);

    // Equal score does not set a new best.
    for (int i = 0; i < 105; i++) frame(8'h00, 1'b1, 1'b0);
    frame(8'h00, 1'b0, 1'b1);
    check("best_equal", 32'(new_best), 32'h0);

    // Collision and score in the same frame: score dropped.
    idle_frames(90);
    start_and_countdown();
    for (int i = 0; i < 41; i++) frame(8'h00, 1'b1, 1'b0);
    frame(8'h00, 1'b1, 1'b1);
    check("tie_score", 32'(score_bcd), 32'h041);
    check("tie_state", 32'(state), 32'h3);

    // Saturation at 999, then asynchronous reset mid-play.
    idle_frames(90);
    start_and_countdown();
    for (int i = 0; i < 1001; i++) frame(8'h00, 1'b1, 1'b0);
    check("sat_999", 32'(score_bcd), 32'h999);
    #2 Reset = 1'b0;
    #1 model_reset();
    compare_all();
    check("async_rst_state", 32'(state), 32'h0);
    @(negedge frame_clk);
    key = 8'h00; score = 1'b0; gameover = 1'b0;
    Reset = 1'b1;

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [7:0] k;
      r = int'($urandom_range(0, 9));
      k = (r <= 2) ? 8'h2C : ((r == 3) ? 8'h1A : 8'h00);
      frame(k, $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
